// File: rtl/bsg_chip_mon_pkg.sv
// Shared types for the chip-top traffic monitor: FSM states and the ready_and link layout.
// The link macro lives here so every file after the package can size links to its own flit width.
`define BSG_READY_AND_LINK_SIF(width) struct packed { logic v; logic [(width)-1:0] data; logic ready_and_rev; }

package bsg_chip_mon_pkg;

  localparam int flit_width_p = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } mon_state_e;

  typedef `BSG_READY_AND_LINK_SIF(flit_width_p) link_sif_t;

endpackage

// File: rtl/bsg_chip_mon_counter.sv
// Single flit counter: clear loads this cycle's event bit, otherwise +1 per event.
// Wraps by default; BSG_CHIP_MON_SATURATE_EN makes it stick at all-ones.
module bsg_chip_mon_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {{(width_p-1){1'b0}}, inc_i};
    end else if (inc_i) begin
`ifdef BSG_CHIP_MON_SATURATE_EN
      if (!(&count_q)) count_d = count_q + 1'b1;
`else
      count_d = count_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_wormhole_router.sv
// Unbuffered dimension-ordered wormhole router; links pass combinationally, no added latency.
// An output is held by one input from header until the last body flit; blocked inputs see ready low.
module bsg_wormhole_router #(
  parameter int flit_width_p = 32,
  parameter int dims_p       = 2,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  localparam int dirs_lp       = 2*dims_p + 1,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [cord_width_p-1:0]                my_cord_i,
  input  logic [dirs_lp-1:0][link_width_lp-1:0]  links_i,
  output logic [dirs_lp-1:0][link_width_lp-1:0]  links_o
);

  localparam int dir_w_lp = $clog2(dirs_lp);
  localparam int cw_lp    = cord_width_p / dims_p;

  typedef `BSG_READY_AND_LINK_SIF(flit_width_p) link_s;

  link_s [dirs_lp-1:0] li, lo;
  assign li      = links_i;
  assign links_o = lo;

  logic [dirs_lp-1:0]                busy_d, busy_q;
  logic [dirs_lp-1:0][dir_w_lp-1:0]  dir_d, dir_q, hdr_dir, sel_i;
  logic [dirs_lp-1:0][len_width_p-1:0] rem_d, rem_q;
  logic [dirs_lp-1:0]                sel_v, owned;

  // Resolve the lowest dimension first: low side is 2k+1, high side 2k+2, P is 0.
  function automatic logic [dir_w_lp-1:0] route(input logic [cord_width_p-1:0] dest,
                                                 input logic [cord_width_p-1:0] mine);
    logic [dir_w_lp-1:0] r;
    logic found;
    r = '0;
    found = 1'b0;
    for (int k = 0; k < dims_p; k++) begin
      if (!found && dest[k*cw_lp +: cw_lp] < mine[k*cw_lp +: cw_lp]) begin
        r = dir_w_lp'(2*k + 1);
        found = 1'b1;
      end else if (!found && dest[k*cw_lp +: cw_lp] > mine[k*cw_lp +: cw_lp]) begin
        r = dir_w_lp'(2*k + 2);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < dirs_lp; i++) hdr_dir[i] = route(li[i].data[cord_width_p-1:0], my_cord_i);
  end

  always_comb begin
    lo    = '0;
    sel_v = '0;
    sel_i = '0;
    owned = '0;
    for (int o = 0; o < dirs_lp; o++) begin
      for (int i = 0; i < dirs_lp; i++) begin
        if (busy_q[i] && int'(dir_q[i]) == o) begin
          owned[o] = 1'b1;
          sel_v[o] = 1'b1;
          sel_i[o] = dir_w_lp'(i);
        end
      end
      // Free outputs go to the lowest-numbered waiting header.
      if (!owned[o]) begin
        for (int i = dirs_lp-1; i >= 0; i--) begin
          if (!busy_q[i] && li[i].v && int'(hdr_dir[i]) == o) begin
            sel_v[o] = 1'b1;
            sel_i[o] = dir_w_lp'(i);
          end
        end
      end
      lo[o].v    = sel_v[o] & li[sel_i[o]].v;
      lo[o].data = li[sel_i[o]].data;
    end
    for (int i = 0; i < dirs_lp; i++) begin
      for (int o = 0; o < dirs_lp; o++) begin
        if (sel_v[o] && int'(sel_i[o]) == i) lo[i].ready_and_rev = li[o].ready_and_rev;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    dir_d  = dir_q;
    rem_d  = rem_q;
    for (int i = 0; i < dirs_lp; i++) begin
      if (li[i].v && lo[i].ready_and_rev) begin
        if (!busy_q[i]) begin
          if (li[i].data[cord_width_p +: len_width_p] != '0) begin
            busy_d[i] = 1'b1;
            dir_d[i]  = hdr_dir[i];
            rem_d[i]  = li[i].data[cord_width_p +: len_width_p];
          end
        end else begin
          rem_d[i] = rem_q[i] - 1'b1;
          if (rem_q[i] == len_width_p'(1)) busy_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= '0;
      dir_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dir_q  <= dir_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/bsg_chip_mon_router.sv
// Chip-top router wrapper with per-direction ingress/egress flit counters snapshotted into a serial scan chain.
// Links are untouched (zero added latency); saturating counters under BSG_CHIP_MON_SATURATE_EN.
module bsg_chip_mon_router
  import bsg_chip_mon_pkg::*;
#(
  parameter int flit_width_p       = 32,
  parameter int dims_p             = 2,
  parameter int cord_width_p       = 8,
  parameter int len_width_p        = 4,
  parameter int ctr_width_p        = 16,
  parameter int clear_on_capture_p = 1,
  localparam int dirs_lp       = 2*dims_p + 1,
  localparam int link_width_lp = flit_width_p + 2,
  localparam int chain_len_lp  = 2*dirs_lp*ctr_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [cord_width_p-1:0]               my_cord_i,
  input  logic [dirs_lp-1:0][link_width_lp-1:0] links_i,
  output logic [dirs_lp-1:0][link_width_lp-1:0] links_o,
  input  logic                                  capture_i,
  input  logic                                  shift_i,
  input  logic                                  scan_i,
  output logic                                  scan_o,
  output logic                                  scan_done_o,
  output logic                                  busy_o
);

  localparam int sc_w_lp = $clog2(chain_len_lp);
  localparam logic [sc_w_lp-1:0] last_lp = sc_w_lp'(chain_len_lp - 1);

  typedef `BSG_READY_AND_LINK_SIF(flit_width_p) link_s;

  link_s [dirs_lp-1:0] li, lo;
  assign li = links_i;
  assign lo = links_o;

  bsg_wormhole_router #(
    .flit_width_p (flit_width_p),
    .dims_p       (dims_p),
    .cord_width_p (cord_width_p),
    .len_width_p  (len_width_p)
  ) router (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .my_cord_i (my_cord_i),
    .links_i   (links_i),
    .links_o   (links_o)
  );

  mon_state_e                state_d, state_q;
  logic [chain_len_lp-1:0]   shadow_d, shadow_q, ctr_flat;
  logic [sc_w_lp-1:0]        shift_cnt_d, shift_cnt_q;
  logic [dirs_lp-1:0]        in_evt, out_evt;
  logic                      clear;

  // Clearing on the capture cycle reloads each counter with that cycle's event, so nothing is lost.
  assign clear = (state_q == CAPTURE) && (clear_on_capture_p != 0);

  for (genvar d = 0; d < dirs_lp; d++) begin : g_dir
    assign in_evt[d]  = li[d].v & lo[d].ready_and_rev;
    assign out_evt[d] = lo[d].v & li[d].ready_and_rev;

    bsg_chip_mon_counter #(.width_p(ctr_width_p)) in_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear),
      .inc_i   (in_evt[d]),
      .count_o (ctr_flat[(2*d)*ctr_width_p +: ctr_width_p])
    );

    bsg_chip_mon_counter #(.width_p(ctr_width_p)) out_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear),
      .inc_i   (out_evt[d]),
      .count_o (ctr_flat[(2*d+1)*ctr_width_p +: ctr_width_p])
    );
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    shift_cnt_d = shift_cnt_q;
    case (state_q)
      IDLE: begin
        if (capture_i) begin
          state_d = CAPTURE;
        end else if (shift_i) begin
          state_d     = SHIFT;
          shift_cnt_d = '0;
        end
      end
      CAPTURE: begin
        shadow_d = ctr_flat;
        state_d  = IDLE;
      end
      SHIFT: begin
        shadow_d    = {scan_i, shadow_q[chain_len_lp-1:1]};
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == last_lp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign scan_o      = shadow_q[0];
  assign scan_done_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);

endmodule
